// File: rtl/blctrl_scheduler.sv
// blctrl_scheduler: periodic BL-Ctrl speed-write sequencer.
//
// On every refresh tick (while masterEnable is high) the eight target speeds and the motor
// enable mask are snapshotted, then one addressed single-byte write per enabled motor is
// handed to the shared I2C byte-transaction engine, strictly motor1..motor8, one at a time.
// Per-motor NACK/timeout status and tick overruns are kept as sticky flags.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   masterEnable      allows frames to start; dropping it ends the frame after the current motor
//   motorEnable[7:0]  bit0 = motor1; disabled motors are skipped
//   targetSpeedFlat   motor1 in [63:56] ... motor8 in [7:0]
//   clear_flags       one-cycle pulse clearing nack_flags and overrun
//   cmd_valid/ready   valid/ready handshake towards the I2C master
//   cmd_addr/data     7-bit device address and speed byte of the pending command
//   cmd_done/err      transaction completion pulse, err qualified by done (NACK)
//   busy              frame in progress
//   active_motor      index of the motor being served (0 = motor1)
//   nack_flags        sticky per-motor NACK or timeout
//   overrun           sticky: a tick arrived while a frame was still running
//   frame_count       completed frames, wrapping 16-bit counter
module blctrl_scheduler #(
    parameter int unsigned REFRESH_TICKS  = 32000,
    parameter logic [6:0]  BASE_ADDR      = 7'h29,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        masterEnable,
    input  logic [7:0]  motorEnable,
    input  logic [63:0] targetSpeedFlat,
    input  logic        clear_flags,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [6:0]  cmd_addr,
    output logic [7:0]  cmd_data,
    input  logic        cmd_done,
    input  logic        cmd_err,
    output logic        busy,
    output logic [2:0]  active_motor,
    output logic [7:0]  nack_flags,
    output logic        overrun,
    output logic [15:0] frame_count
);

    localparam int unsigned TimerW = (REFRESH_TICKS > 1) ? $clog2(REFRESH_TICKS) : 1;
    localparam int unsigned TmoW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TimerW-1:0] TimerLast = TimerW'(REFRESH_TICKS - 1);
    localparam logic [TmoW-1:0]   TmoLast   = TmoW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StScan,
        StIssue,
        StWait,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [TmoW-1:0]   tmo_q, tmo_d;
    logic [2:0]        idx_q, idx_d;
    logic [63:0]       snap_speed_q, snap_speed_d;
    logic [7:0]        snap_en_q, snap_en_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic [6:0]        cmd_addr_q, cmd_addr_d;
    logic [7:0]        cmd_data_q, cmd_data_d;
    logic [7:0]        nack_q, nack_d;
    logic              overrun_q, overrun_d;
    logic [15:0]       frame_q, frame_d;

    logic              tick;
    logic              leave_wait;
    logic [7:0]        snap_byte [8];

    assign tick = (timer_q == TimerLast);

    // Byte n of the snapshot belongs to motor n+1; motor1 sits in the top byte.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            snap_byte[i] = snap_speed_q[8*(7-i) +: 8];
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        tmo_d        = tmo_q;
        snap_speed_d = snap_speed_q;
        snap_en_d    = snap_en_q;
        cmd_valid_d  = cmd_valid_q;
        cmd_addr_d   = cmd_addr_q;
        cmd_data_d   = cmd_data_q;
        frame_d      = frame_q;
        leave_wait   = 1'b0;
        timer_d      = tick ? '0 : timer_q + 1'b1;

        // Clear first so that a set event in the same cycle wins for its bit.
        nack_d    = clear_flags ? 8'h00 : nack_q;
        overrun_d = (clear_flags ? 1'b0 : overrun_q) | (tick && (state_q != StIdle));

        unique case (state_q)
            StIdle: begin
                if (tick && masterEnable) begin
                    snap_speed_d = targetSpeedFlat;
                    snap_en_d    = motorEnable;
                    idx_d        = 3'd0;
                    state_d      = StScan;
                end
            end
            StScan: begin
                if (snap_en_q[idx_q]) begin
                    cmd_valid_d = 1'b1;
                    cmd_addr_d  = BASE_ADDR + {4'b0000, idx_q};
                    cmd_data_d  = snap_byte[idx_q];
                    state_d     = StIssue;
                end else if (idx_q == 3'd7) begin
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            StIssue: begin
                // cmd_valid is held high here, so ready alone completes the handshake.
                if (cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    tmo_d       = '0;
                    state_d     = StWait;
                end
            end
            StWait: begin
                if (cmd_done) begin
                    if (cmd_err) begin
                        nack_d[idx_q] = 1'b1;
                    end
                    leave_wait = 1'b1;
                end else if (tmo_q == TmoLast) begin
                    nack_d[idx_q] = 1'b1;
                    leave_wait    = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
                if (leave_wait) begin
                    if ((idx_q == 3'd7) || !masterEnable) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = StScan;
                    end
                end
            end
            StDone: begin
                frame_d = frame_q + 16'd1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            timer_q      <= '0;
            tmo_q        <= '0;
            idx_q        <= 3'd0;
            snap_speed_q <= 64'h0;
            snap_en_q    <= 8'h00;
            cmd_valid_q  <= 1'b0;
            cmd_addr_q   <= 7'h00;
            cmd_data_q   <= 8'h00;
            nack_q       <= 8'h00;
            overrun_q    <= 1'b0;
            frame_q      <= 16'h0000;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            tmo_q        <= tmo_d;
            idx_q        <= idx_d;
            snap_speed_q <= snap_speed_d;
            snap_en_q    <= snap_en_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_addr_q   <= cmd_addr_d;
            cmd_data_q   <= cmd_data_d;
            nack_q       <= nack_d;
            overrun_q    <= overrun_d;
            frame_q      <= frame_d;
        end
    end

    assign cmd_valid    = cmd_valid_q;
    assign cmd_addr     = cmd_addr_q;
    assign cmd_data     = cmd_data_q;
    assign busy         = (state_q != StIdle);
    assign active_motor = idx_q;
    assign nack_flags   = nack_q;
    assign overrun      = overrun_q;
    assign frame_count  = frame_q;

endmodule

// File: doc/blctrl_scheduler.md
Name: blctrl_scheduler

Overview:
- Sequences periodic BL-Ctrl speed writes over the shared I2C master.
- Sits between the eight DShot speed decoders and the I2C byte-transaction engine.
- On each refresh tick it snapshots all eight target speeds, then issues one addressed single-byte write per enabled motor.
- Issues writes strictly in order motor1..motor8, one at a time, and records per-motor NACK/timeout status.

Parameters:
- REFRESH_TICKS, 32000, clk cycles between frame ticks (500 Hz at 16 MHz).
- BASE_ADDR, 7'h29, 7-bit I2C address of motor1; motor n uses BASE_ADDR+n-1.
- TIMEOUT_CYCLES, 4096, maximum clk cycles from command acceptance to cmd_done.

Ports:
- clk  in  1  system clock (16 MHz)
- rst  in  1  synchronous, active-high reset
- masterEnable  in  1  allows frames to start
- motorEnable  in  8  bit0 = motor1; disabled motors are skipped
- targetSpeedFlat  in  64  motor1 in [63:56] ... motor8 in [7:0]
- clear_flags  in  1  one-cycle pulse clearing sticky flags
- cmd_valid  out  1  command request to I2C master
- cmd_ready  in  1  I2C master accepts command
- cmd_addr  out  7  target device address
- cmd_data  out  8  speed byte
- cmd_done  in  1  one-cycle pulse: transaction finished
- cmd_err  in  1  qualified by cmd_done: address/data NACK
- busy  out  1  frame in progress (state != IDLE)
- active_motor  out  3  index of current motor (0 = motor1)
- nack_flags  out  8  sticky per-motor NACK or timeout
- overrun  out  1  sticky: tick arrived while busy
- frame_count  out  16  completed frames, wraps 16'hFFFF -> 0

Behaviour:
- Reset values: cmd_valid=0, cmd_addr=0, cmd_data=0, busy=0, active_motor=0, nack_flags=0, overrun=0, frame_count=0, timer=0, state=IDLE.
- Timer: free-running 0..REFRESH_TICKS-1. tick=1 in the cycle timer==REFRESH_TICKS-1, then timer wraps to 0.
- FSM states: IDLE, SCAN, ISSUE, WAIT, DONE.
- IDLE:
  - On tick with masterEnable=1: latch targetSpeedFlat and motorEnable into snapshot registers; idx=0; go to SCAN.
  - Tick with masterEnable=0 is ignored.
- SCAN:
  - If snapshot enable[idx]=1: load cmd_addr=BASE_ADDR+idx and cmd_data=snapshot byte idx; set cmd_valid=1; go to ISSUE. cmd_valid is therefore first high 2 cycles after the tick.
  - Else if idx==7: go to DONE.
  - Else: idx++ (one cycle per skipped motor).
- ISSUE:
  - Hold cmd_valid, cmd_addr and cmd_data stable until cmd_valid && cmd_ready.
  - On that cycle: cmd_valid<=0, clear the timeout counter, go to WAIT.
  - cmd_valid is never withdrawn before acceptance.
- WAIT:
  - On cmd_done: if cmd_err=1, set nack_flags[idx].
  - If timeout counter reaches TIMEOUT_CYCLES-1 without cmd_done: set nack_flags[idx] and abandon that motor.
  - cmd_done and timeout in the same cycle: cmd_done wins.
  - Leaving WAIT: if idx==7 or masterEnable==0, go to DONE; else idx++ and go to SCAN.
- DONE: frame_count++ (16-bit wrap); go to IDLE. A frame aborted by masterEnable still counts.
- Snapshot coherence: targetSpeedFlat and motorEnable changes mid-frame have no effect until the next frame.
- Overrun: a tick in any state other than IDLE sets overrun. That tick is dropped, not queued.
- Frame with all motors disabled: SCAN walks 8 cycles, DONE increments frame_count, no cmd_valid.
- clear_flags clears nack_flags and overrun. If a flag set event occurs in the same cycle, the set wins for that bit.
- masterEnable deasserted during ISSUE: the handshake still completes and the transaction is awaited, then DONE.
- rst mid-frame: immediate return to reset values next cycle, with cmd_valid dropped. The I2C master is reset from the same rst.
- busy is combinational from state (high in SCAN/ISSUE/WAIT/DONE). active_motor=idx.

Test Plan:
- REFRESH_TICKS=200, all enabled, speeds 8'h10..8'h17, cmd_ready=1, cmd_done 5 cycles after accept -> 8 commands, addrs 0x29..0x30 with data 0x10..0x17 in order; cmd_valid rises exactly 2 cycles after tick; frame_count=1.
- motorEnable=8'b1010_0101 -> only addrs 0x29,0x2B,0x2E,0x30 issued; frame_count increments; motorEnable=0 -> no cmd_valid, frame_count still increments.
- Hold cmd_ready=0 for 20 cycles while changing targetSpeedFlat -> cmd_valid, cmd_addr and cmd_data stable throughout; data equals the snapshot value.
- cmd_err=1 on motor3's cmd_done; motor6 never gets cmd_done -> nack_flags=8'h24 after TIMEOUT_CYCLES; then clear_flags -> 8'h00.
- Stall cmd_done past a second tick -> overrun=1, the tick is not replayed, next frame starts on the following tick.
- Assert rst while in WAIT for motor4 -> next cycle all outputs at reset values; the frame restarts cleanly on the next tick.
